if_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the IF stage: owns the PC and drives the synchronous instruction ROM
//  (1-cycle read latency). Delivers {pc, instr} to ID over a valid/ready handshake.

---
 rtl/if_fetch_ctrl_if.sv | 24 ++
 rtl/if_fetch_ctrl.sv | 114 +++++++++++
 tb/tb_if_fetch_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_if.sv
// Fetch-side bundle: control inputs, synchronous ROM port and the ID valid/ready handshake.
// master = fetch controller, slave = surrounding pipeline/ROM.
interface if_fetch_ctrl_if #(parameter int ADDR_W = 10);
   logic              fetch_en;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0]       rom_data;
   logic              id_valid;
   logic              id_ready;
   logic [31:0]       id_pc;
   logic [31:0]       id_instr;

   modport master (
      input  fetch_en, redirect_valid, redirect_pc, rom_data, id_ready,
      output rom_en, rom_addr, id_valid, id_pc, id_instr
   );

   modport slave (
      output fetch_en, redirect_valid, redirect_pc, rom_data, id_ready,
      input  rom_en, rom_addr, id_valid, id_pc, id_instr
   );
endinterface

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, drives a 1-cycle synchronous ROM, 1-entry hold on stall.
// Optional FETCH_PERF_CNT_EN adds accepted-fetch and stall-cycle counters.
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   if_fetch_ctrl_if.master        bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]            perf_fetch_cnt_o,
   output logic [31:0]            perf_stall_cnt_o
`endif
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic        out_vld_q, out_vld_d;

   logic [31:0] tgt_pc, issued_pc;
   logic        redir, slot_free, issue, id_vld;

   always_comb begin
      tgt_pc    = bus.redirect_pc & 32'hFFFF_FFFC;
      redir     = bus.redirect_valid & !rst;
      slot_free = !out_vld_q | bus.id_ready;
      issue     = !rst & bus.fetch_en &
                  (redir | ((state_q != HOLD) ? slot_free : bus.id_ready));
      issued_pc = redir ? tgt_pc : pc_q;
      id_vld    = out_vld_q & !redir & !rst;

      state_d   = state_q;
      pc_d      = pc_q;
      req_pc_d  = req_pc_q;
      hold_d    = hold_q;
      hold_pc_d = hold_pc_q;

      if (issue) begin
         pc_d     = issued_pc + 32'd4;
         req_pc_d = issued_pc;
      end else if (redir) begin
         pc_d = tgt_pc;
      end

      case (state_q)
         IDLE: if (issue) state_d = RUN;
         RUN: begin
            if (redir) begin
               state_d = bus.fetch_en ? RUN : IDLE;
            end else if (out_vld_q && !bus.id_ready) begin
               // ROM output is only good for one cycle; park it before it is lost
               hold_d    = bus.rom_data;
               hold_pc_d = req_pc_q;
               state_d   = HOLD;
            end else if (!bus.fetch_en) begin
               state_d = IDLE;
            end
         end
         HOLD: if (redir || bus.id_ready) state_d = bus.fetch_en ? RUN : IDLE;
         default: state_d = IDLE;
      endcase

      // a held instruction stays presented until accepted or squashed
      out_vld_d = issue | (state_d == HOLD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         req_pc_q  <= RESET_PC;
         hold_q    <= 32'd0;
         hold_pc_q <= RESET_PC;
         out_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         req_pc_q  <= req_pc_d;
         hold_q    <= hold_d;
         hold_pc_q <= hold_pc_d;
         out_vld_q <= out_vld_d;
      end
   end

   assign bus.rom_en   = issue;
   assign bus.rom_addr = issued_pc[ADDR_W+1:2];
   assign bus.id_valid = id_vld;
   assign bus.id_pc    = (state_q == HOLD) ? hold_pc_q : req_pc_q;
   assign bus.id_instr = (state_q == HOLD) ? hold_q : (out_vld_q ? bus.rom_data : 32'd0);

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_q, perf_stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_q <= 32'd0;
         perf_stall_q <= 32'd0;
      end else begin
         if (id_vld && bus.id_ready)  perf_fetch_q <= perf_fetch_q + 32'd1;
         if (id_vld && !bus.id_ready) perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_fetch_cnt_o = perf_fetch_q;
   assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus randomized traffic against a
// transaction-level model (presented slot + next PC), with a ROM model behind the DUT.
module tb_if_fetch_ctrl;
   localparam int          ADDR_W   = 10;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   if_fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] pf, ps;
`endif

   if_fetch_ctrl #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt_o (pf),
      .perf_stall_cnt_o (ps)
`endif
   );

   logic [31:0] rom [0:(1<<ADDR_W)-1];
   always @(posedge clk) if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];

   int n_cmp = 0;
   int n_err = 0;

   // model: presented slot (valid, pc) and the next sequential fetch pc
   logic        m_pv;
   logic [31:0] m_ppc, m_npc;
   logic [31:0] m_fc, m_sc;
   logic        e_vld, e_en;
   logic [31:0] e_tgt, e_ipc, e_pc, e_instr;
   logic [ADDR_W-1:0] e_addr;

   task automatic drive(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
      bus.fetch_en = fe; bus.redirect_valid = rv; bus.redirect_pc = rpc; bus.id_ready = rdy;
      e_tgt   = {rpc[31:2], 2'b00};
      e_vld   = !rst && m_pv && !rv;
      e_en    = !rst && fe && (rv || !m_pv || rdy);
      e_ipc   = rv ? e_tgt : m_npc;
      e_addr  = e_ipc[ADDR_W+1:2];
      e_pc    = m_ppc;
      e_instr = rom[m_ppc[ADDR_W+1:2]];
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_pv = 1'b0; m_ppc = RESET_PC; m_npc = RESET_PC; m_fc = 0; m_sc = 0;
      end else begin
         if (e_vld && bus.id_ready)  m_fc = m_fc + 1;
         if (e_vld && !bus.id_ready) m_sc = m_sc + 1;
         if (e_en) begin
            m_pv = 1'b1; m_ppc = e_ipc; m_npc = e_ipc + 32'd4;
         end else if (bus.redirect_valid) begin
            m_pv = 1'b0; m_npc = e_tgt;
         end else if (e_vld && bus.id_ready) begin
            m_pv = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; drive(1'b0, 1'b0, 32'd0, 1'b0); tick(); rst = 1'b0;
   endtask

   // runs 0x0 and 0x4 through, leaves 0x8 presented
   task automatic prime_to_8();
      for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 32'd0, 1'b1); tick(); end
   endtask

   task automatic test_reset();
      do_reset();
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL reset_id_valid got %b want 0", bus.id_valid); end
      n_cmp++; if (bus.rom_en !== 1'b0) begin n_err++; $display("FAIL reset_rom_en got %b want 0", bus.rom_en); end
      n_cmp++; if (bus.id_pc !== RESET_PC) begin n_err++; $display("FAIL reset_id_pc got %h want %h", bus.id_pc, RESET_PC); end
      n_cmp++; if (bus.id_instr !== 32'd0) begin n_err++; $display("FAIL reset_id_instr got %h want 0", bus.id_instr); end
      tick();
   endtask

   task automatic test_stream();
      logic [31:0] w;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, 32'd0, 1'b1);
         n_cmp++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== ADDR_W'(i)) begin
            n_err++; $display("FAIL stream_rom i=%0d got en=%b addr=%h want en=1 addr=%h", i, bus.rom_en, bus.rom_addr, i); end
         n_cmp++; if (bus.id_valid !== (i > 0)) begin
            n_err++; $display("FAIL stream_valid i=%0d got %b want %b", i, bus.id_valid, i > 0); end
         if (i > 0) begin
            w = rom[i-1];
            n_cmp++; if (bus.id_pc !== 32'((i-1)*4) || bus.id_instr !== w) begin
               n_err++; $display("FAIL stream_out i=%0d got pc=%h instr=%h want pc=%h instr=%h", i, bus.id_pc, bus.id_instr, (i-1)*4, w); end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] w8;
      do_reset(); prime_to_8();
      w8 = rom[2];
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 32'd0, 1'b0);
         n_cmp++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h8 || bus.id_instr !== w8 || bus.rom_en !== 1'b0) begin
            n_err++; $display("FAIL stall k=%0d got v=%b pc=%h instr=%h en=%b want v=1 pc=8 instr=%h en=0",
                              k, bus.id_valid, bus.id_pc, bus.id_instr, bus.rom_en, w8); end
         tick();
      end
      drive(1'b1, 1'b0, 32'd0, 1'b1);
      n_cmp++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h8 || bus.rom_en !== 1'b1 || bus.rom_addr !== 10'h3) begin
         n_err++; $display("FAIL release got v=%b pc=%h en=%b addr=%h want v=1 pc=8 en=1 addr=3",
                           bus.id_valid, bus.id_pc, bus.rom_en, bus.rom_addr); end
      tick();
      drive(1'b1, 1'b0, 32'd0, 1'b1);
      n_cmp++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'hC) begin
         n_err++; $display("FAIL no_bubble got v=%b pc=%h want v=1 pc=c", bus.id_valid, bus.id_pc); end
      tick();
   endtask

   task automatic test_redirect_hold();
      logic [31:0] w;
      do_reset(); prime_to_8();
      drive(1'b1, 1'b0, 32'd0, 1'b0); tick();
      drive(1'b1, 1'b0, 32'd0, 1'b0); tick();
      drive(1'b1, 1'b1, 32'h103, 1'b1);
      n_cmp++; if (bus.id_valid !== 1'b0 || bus.rom_en !== 1'b1 || bus.rom_addr !== 10'h40) begin
         n_err++; $display("FAIL redir_hold got v=%b en=%b addr=%h want v=0 en=1 addr=40", bus.id_valid, bus.rom_en, bus.rom_addr); end
      tick();
      drive(1'b1, 1'b0, 32'd0, 1'b1);
      w = rom[10'h40];
      n_cmp++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h100 || bus.id_instr !== w) begin
         n_err++; $display("FAIL redir_target got v=%b pc=%h instr=%h want v=1 pc=100 instr=%h", bus.id_valid, bus.id_pc, bus.id_instr, w); end
      tick();
   endtask

   task automatic test_wrap();
      do_reset();
      drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
      n_cmp++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 10'h3FF) begin
         n_err++; $display("FAIL wrap_addr0 got en=%b addr=%h want en=1 addr=3ff", bus.rom_en, bus.rom_addr); end
      tick();
      drive(1'b1, 1'b0, 32'd0, 1'b1);
      n_cmp++; if (bus.id_pc !== 32'hFFFF_FFFC || bus.rom_addr !== 10'h0) begin
         n_err++; $display("FAIL wrap_pc0 got pc=%h addr=%h want pc=fffffffc addr=0", bus.id_pc, bus.rom_addr); end
      tick();
      drive(1'b1, 1'b0, 32'd0, 1'b1);
      n_cmp++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0) begin
         n_err++; $display("FAIL wrap_pc1 got v=%b pc=%h want v=1 pc=0", bus.id_valid, bus.id_pc); end
      tick();
   endtask

   task automatic test_reset_in_hold();
      do_reset(); prime_to_8();
      drive(1'b1, 1'b0, 32'd0, 1'b0); tick();
      drive(1'b1, 1'b0, 32'd0, 1'b0); tick();
      rst = 1'b1; drive(1'b1, 1'b0, 32'd0, 1'b0); tick(); rst = 1'b0;
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      n_cmp++; if (bus.id_valid !== 1'b0 || bus.rom_en !== 1'b0 || bus.id_pc !== RESET_PC) begin
         n_err++; $display("FAIL rst_hold got v=%b en=%b pc=%h want v=0 en=0 pc=%h", bus.id_valid, bus.rom_en, bus.id_pc, RESET_PC); end
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      n_cmp++; if (bus.rom_en !== 1'b0) begin n_err++; $display("FAIL rst_idle_en got %b want 0", bus.rom_en); end
      tick();
      drive(1'b1, 1'b0, 32'd0, 1'b1);
      n_cmp++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== RESET_PC[ADDR_W+1:2]) begin
         n_err++; $display("FAIL rst_restart got en=%b addr=%h want en=1 addr=%h", bus.rom_en, bus.rom_addr, RESET_PC[ADDR_W+1:2]); end
      tick();
   endtask

`ifdef FETCH_PERF_CNT_EN
   task automatic test_perf();
      logic [7:0] pat;
      pat = 8'b1110_0011;
      do_reset();
      drive(1'b1, 1'b0, 32'd0, 1'b1); tick();
      for (int i = 0; i < 8; i++) begin drive(1'b1, 1'b0, 32'd0, pat[i]); tick(); end
      drive(1'b0, 1'b1, 32'd0, 1'b0);
      n_cmp++; if (pf !== 32'd5 || ps !== 32'd3) begin
         n_err++; $display("FAIL perf got fetch=%0d stall=%0d want fetch=5 stall=3", pf, ps); end
      tick();
   endtask
`endif

   task automatic test_random();
      logic fe, rv, rdy;
      logic [31:0] rpc;
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         fe  = ($urandom_range(0, 9) != 0);
         rv  = ($urandom_range(0, 7) == 0);
         rdy = ($urandom_range(0, 2) != 0);
         rpc = $urandom;
         drive(fe, rv, rpc, rdy);
         n_cmp++; if (bus.rom_en !== e_en || bus.id_valid !== e_vld) begin
            n_err++; $display("FAIL rnd_ctl c=%0d got en=%b v=%b want en=%b v=%b", c, bus.rom_en, bus.id_valid, e_en, e_vld); end
         if (e_en) begin
            n_cmp++; if (bus.rom_addr !== e_addr) begin
               n_err++; $display("FAIL rnd_addr c=%0d got %h want %h", c, bus.rom_addr, e_addr); end
         end
         if (e_vld) begin
            n_cmp++; if (bus.id_pc !== e_pc || bus.id_instr !== e_instr) begin
               n_err++; $display("FAIL rnd_out c=%0d got pc=%h instr=%h want pc=%h instr=%h", c, bus.id_pc, bus.id_instr, e_pc, e_instr); end
         end
`ifdef FETCH_PERF_CNT_EN
         n_cmp++; if (pf !== m_fc || ps !== m_sc) begin
            n_err++; $display("FAIL rnd_perf c=%0d got %0d/%0d want %0d/%0d", c, pf, ps, m_fc, m_sc); end
`endif
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = $urandom;
      m_pv = 1'b0; m_ppc = RESET_PC; m_npc = RESET_PC; m_fc = 0; m_sc = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_hold();
      test_wrap();
      test_reset_in_hold();
`ifdef FETCH_PERF_CNT_EN
      test_perf();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
